// File: rtl/video_pkg.sv
// Shared constants and state encoding for the text-mode video path.
package video_pkg;
    localparam int COLS        = 80;
    localparam int GLYPH_W     = 8;
    localparam int ROW_BITS    = 4;
    localparam int CODE_W      = 8;
    localparam int FONT_ADDR_W = 12;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/glyph_shift_reg.sv
// Glyph row register: loads one ROM row (optionally inverted) and shifts it out MSB first.
module glyph_shift_reg
    import video_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               clear,
    input  logic [GLYPH_W-1:0] data,
    input  logic               inv,
    output logic               pixel
);
    logic [GLYPH_W-1:0] sr;

    // Zero fill means an unloaded register drains to background on its own.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            sr <= '0;
        end else if (load) begin
            sr <= data ^ {GLYPH_W{inv}};
        end else begin
            sr <= {sr[GLYPH_W-2:0], 1'b0};
        end
    end

    assign pixel = sr[GLYPH_W-1];
endmodule

// File: rtl/glyph_serializer.sv
// Font ROM reader: fetches one glyph row per column and streams it as one pixel per clock.
module glyph_serializer
    import video_pkg::*;
#(
    parameter int COLS = video_pkg::COLS
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   line_start,
    input  logic [CODE_W-1:0]      char_code,
    input  logic [ROW_BITS-1:0]    glyph_row,
    input  logic                   cursor_here,
    input  logic                   cursor_on,
    output logic                   char_req,
    output logic [FONT_ADDR_W-1:0] rom_addr,
    input  logic [GLYPH_W-1:0]     rom_dout,
    output logic                   pixel_out,
    output logic                   pixel_valid,
    output state_t                 fsm_state
);
    localparam int COL_W = $clog2(COLS + 1);

    // Handshake: char_req has no ready; the char inputs are taken on every edge where it is
    // high and upstream advances its column afterwards. pixel_valid qualifies pixel_out per cycle.

    state_t           state;
    logic [2:0]       bit_cnt;
    logic [2:0]       pix_cnt;
    logic [COL_W-1:0] fetch_col;
    logic [COL_W-1:0] out_col;
    logic             req_d1;
    logic             req_d2;
    logic             inv_d;
    logic             inv_d2;
    logic             restart;
    logic             load;
    logic             finish;

    // bit_cnt is the fetch phase: zeroed on the sampling edge, so its 7 lands two cycles
    // before the current glyph drains, which hides the address + ROM latency.
    assign restart  = line_start && (state == RUN);
    assign char_req = reset_n && (line_start ||
                      ((state == RUN) && (bit_cnt == 3'd7) && (fetch_col < COL_W'(COLS))));
    assign load     = req_d2 && !restart;
    assign finish   = (state == RUN) && !restart && !load && pixel_valid &&
                      (pix_cnt == 3'd7) && (out_col == COL_W'(COLS));
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            pix_cnt     <= '0;
            fetch_col   <= '0;
            out_col     <= '0;
            req_d1      <= 1'b0;
            req_d2      <= 1'b0;
            inv_d       <= 1'b0;
            inv_d2      <= 1'b0;
            rom_addr    <= '0;
            pixel_valid <= 1'b0;
        end else begin
            req_d1 <= char_req;
            // A restart discards whatever fetch is still in the ROM pipeline.
            req_d2 <= req_d1 && !restart;
            inv_d2 <= inv_d;
            if (char_req) begin
                rom_addr <= {char_code, glyph_row};
                inv_d    <= cursor_here && cursor_on;
            end

            if (line_start) begin
                state     <= RUN;
                fetch_col <= COL_W'(1);
                bit_cnt   <= '0;
                out_col   <= '0;
            end else if (state == RUN) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (char_req) begin
                    fetch_col <= fetch_col + COL_W'(1);
                end
                if (load && (out_col < COL_W'(COLS))) begin
                    out_col <= out_col + COL_W'(1);
                end
                if (finish) begin
                    state <= IDLE;
                end
            end

            if (load) begin
                pixel_valid <= 1'b1;
                pix_cnt     <= '0;
            end else if (finish) begin
                pixel_valid <= 1'b0;
                pix_cnt     <= '0;
            end else if (pixel_valid) begin
                pix_cnt <= pix_cnt + 3'd1;
            end
        end
    end

    glyph_shift_reg u_shift (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .clear   (finish),
        .data    (rom_dout),
        .inv     (inv_d2),
        .pixel   (pixel_out)
    );
endmodule

// File: tb/tb_glyph_serializer.sv
// Directed bench for glyph_serializer with a registered font ROM model and pixel scoreboard.
module tb_glyph_serializer;
    import video_pkg::*;

    localparam int TCOLS = 4;

    logic        clk;
    logic        reset_n;
    logic        line_start;
    logic [7:0]  char_code;
    logic [3:0]  glyph_row;
    logic        cursor_here;
    logic        cursor_on;
    logic        char_req;
    logic [11:0] rom_addr;
    logic [7:0]  rom_dout;
    logic        pixel_out;
    logic        pixel_valid;
    state_t      fsm_state;

    logic [7:0]  rom [0:4095];
    logic [7:0]  codes [0:7];

    // Scoreboard entry: {cycle index, expected pixel}
    logic [32:0] exp_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int col = 0;
    int cur_col = -1;
    bit cur_all = 1'b0;
    bit chk_en = 1'b0;
    bit line_active = 1'b0;
    int req_count = 0;
    int last_req = 0;
    int skip_lo = -1;
    int skip_hi = -2;
    int valid_total = 0;
    int v0;

    glyph_serializer #(.COLS(TCOLS)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .line_start  (line_start),
        .char_code   (char_code),
        .glyph_row   (glyph_row),
        .cursor_here (cursor_here),
        .cursor_on   (cursor_on),
        .char_req    (char_req),
        .rom_addr    (rom_addr),
        .rom_dout    (rom_dout),
        .pixel_out   (pixel_out),
        .pixel_valid (pixel_valid),
        .fsm_state   (fsm_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) rom_dout <= rom[rom_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_pixel();
        logic [32:0] e;
        if (cyc >= skip_lo && cyc <= skip_hi) begin
            chk("valid_through_restart", pixel_valid, 1'b1);
        end else if (exp_q.size() != 0 && exp_q[0][32:1] == 32'(cyc)) begin
            e = exp_q.pop_front();
            chk("pixel_valid", pixel_valid, 1'b1);
            chk("pixel_out", pixel_out, e[0]);
        end else begin
            chk("idle_valid", pixel_valid, 1'b0);
            chk("idle_pixel", pixel_out, 1'b0);
        end
        if (pixel_valid === 1'b1) valid_total++;
    endtask

    // One clock: check this cycle's pixel, drive inputs, sample char_req, advance to next negedge.
    task automatic tick(input bit ls, input bit rst);
        int c;
        logic [7:0] g;
        if (chk_en) check_pixel();
        reset_n     = !rst;
        line_start  = ls;
        c           = ls ? 0 : col;
        char_code   = codes[c];
        cursor_here = cur_all || (c == cur_col);
        #2;
        if (rst) begin
            chk("req_in_reset", char_req, 1'b0);
            exp_q.delete();
            line_active = 1'b0;
            col = 0;
        end else begin
            if (ls) begin
                chk("req_on_start", char_req, 1'b1);
                if (exp_q.size() != 0) begin
                    exp_q.delete();
                    skip_lo = cyc + 1;
                    skip_hi = cyc + 2;
                end
                line_active = 1'b1;
                req_count = 0;
            end else if (!(line_active && req_count < TCOLS)) begin
                chk("no_req", char_req, 1'b0);
            end
            if (char_req === 1'b1) begin
                if (!ls) chk("req_spacing", cyc - last_req, 8);
                last_req = cyc;
                req_count++;
                g = rom[{char_code, glyph_row}] ^ {8{cursor_here & cursor_on}};
                for (int i = 0; i < 8; i++) exp_q.push_back({32'(cyc + 3 + i), g[7-i]});
                col = c + 1;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_line(input int exp_valid);
        v0 = valid_total;
        tick(1'b1, 1'b0);
        repeat (40) tick(1'b0, 1'b0);
        chk("req_count", req_count, TCOLS);
        chk("valid_cycles", valid_total - v0, exp_valid);
        chk("state_idle", fsm_state, IDLE);
    endtask

    task automatic set_codes(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
        codes[0] = a; codes[1] = b; codes[2] = c; codes[3] = d;
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) rom[a] = 8'($urandom_range(0, 255));
        rom[12'h415] = 8'h18;
        for (int i = 0; i < 8; i++) codes[i] = 8'h00;
        reset_n = 1'b0; line_start = 1'b0; char_code = 8'h00; glyph_row = 4'h0;
        cursor_here = 1'b0; cursor_on = 1'b0;

        @(negedge clk);
        repeat (3) tick(1'b0, 1'b1);
        chk("rst_pixel_valid", pixel_valid, 1'b0);
        chk("rst_pixel_out", pixel_out, 1'b0);
        chk("rst_rom_addr", rom_addr, 12'h000);
        chk("rst_char_req", char_req, 1'b0);
        chk("rst_state", fsm_state, IDLE);
        chk_en = 1'b1;
        repeat (2) tick(1'b0, 1'b0);

        // Basic fetch: 0x41 row 5 -> address 0x415, ROM 0x18
        set_codes(8'h41, 8'h41, 8'h41, 8'h41);
        glyph_row = 4'd5;
        v0 = valid_total;
        tick(1'b1, 1'b0);
        chk("rom_addr_first", rom_addr, 12'h415);
        repeat (40) tick(1'b0, 1'b0);
        chk("req_count_t1", req_count, TCOLS);
        chk("valid_cycles_t1", valid_total - v0, 32);

        // Mixed codes, random ROM contents
        set_codes(8'h20, 8'h7F, 8'h41, 8'h00);
        glyph_row = 4'd3;
        run_line(32);

        // Cursor on column 1, shown then hidden
        set_codes(8'h41, 8'h41, 8'h41, 8'h41);
        glyph_row = 4'd5;
        cur_col = 1;
        cursor_on = 1'b1;
        run_line(32);
        cursor_on = 1'b0;
        run_line(32);

        // Cursor on every column with blink phase toggling mid-glyph
        cur_all = 1'b1;
        set_codes(8'h41, 8'h13, 8'h41, 8'h99);
        glyph_row = 4'd5;
        v0 = valid_total;
        tick(1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (i % 5 == 2) cursor_on = ~cursor_on;
            tick(1'b0, 1'b0);
        end
        chk("valid_cycles_blink", valid_total - v0, 32);
        cur_all = 1'b0;
        cur_col = -1;
        cursor_on = 1'b0;

        // Restart at pixel 13 of the line
        set_codes(8'h41, 8'h20, 8'h7F, 8'h00);
        glyph_row = 4'd2;
        v0 = valid_total;
        tick(1'b1, 1'b0);
        repeat (15) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        repeat (40) tick(1'b0, 1'b0);
        chk("req_count_restart", req_count, TCOLS);
        chk("valid_cycles_restart", valid_total - v0, 48);
        chk("state_idle_restart", fsm_state, IDLE);

        // One-cycle reset mid-line
        set_codes(8'h55, 8'hAA, 8'h0F, 8'hF0);
        glyph_row = 4'd9;
        tick(1'b1, 1'b0);
        repeat (19) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        chk("req_after_rst", char_req, 1'b0);
        chk("state_after_rst", fsm_state, IDLE);
        chk("valid_after_rst", pixel_valid, 1'b0);
        chk("pixel_after_rst", pixel_out, 1'b0);
        repeat (12) tick(1'b0, 1'b0);
        chk("state_held_idle", fsm_state, IDLE);
        run_line(32);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
